// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: shared state encoding and default debounce length for debug_run_ctrl
package run_ctrl_pkg;
  typedef enum logic [1:0] {
    HALT     = 2'd0,
    RUN      = 2'd1,
    STEP_CYC = 2'd2,
    STEP_INS = 2'd3
  } state_t;
  localparam int DEBOUNCE_DEFAULT = 50000;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronises a raw button and emits a one-cycle pulse on each debounced press
module btn_debounce
  import run_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic level;
  logic diff, done;
  assign diff = sync[1] != level;
  assign done = cnt == CW'(DEBOUNCE_CYCLES - 1);
  // level follows the synced button only after it has differed for DEBOUNCE_CYCLES cycles in a row
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], btn};
      press <= diff & done & sync[1];
      cnt   <= (diff & !done) ? cnt + CW'(1) : '0;
      level <= (diff & done) ? sync[1] : level;
    end
  end
endmodule

// File: rtl/debug_run_ctrl.sv
// debug_run_ctrl: run/step/breakpoint controller driving the datapath clock enable
module debug_run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH      = 16,
  parameter int NUM_BP          = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_btnStep,
  input  logic                         i_swInstrNCycle,
  input  logic                         i_swStepNRun,
  input  logic                         i_swEnableBreakpoint,
  input  logic [NUM_BP*ADDR_WIDTH-1:0] i_bpAddresses,
  input  logic [NUM_BP-1:0]            i_bpValid,
  input  logic                         i_instrDone,
  input  logic [ADDR_WIDTH-1:0]        i_pc,
  output logic                         o_cpuEnable,
  output logic                         o_halted,
  output logic [NUM_BP-1:0]            o_bpHit,
  output logic [CNT_WIDTH-1:0]         o_cycleCount,
  output logic [CNT_WIDTH-1:0]         o_instrCount
);
  state_t state, next;
  logic [1:0] instr_sync, step_sync, bp_sync, warm;
  logic [NUM_BP-1:0] bp_match;
  logic step_req, done, checked, hit, leave;
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk  (i_clk),
    .rst  (i_reset),
    .btn  (i_btnStep),
    .press(step_req)
  );
  // switch synchronisers; warm holds the FSM in HALT until the chains carry real switch values
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      instr_sync <= '0;
      step_sync  <= '0;
      bp_sync    <= '0;
      warm       <= '0;
    end else begin
      instr_sync <= {instr_sync[0], i_swInstrNCycle};
      step_sync  <= {step_sync[0], i_swStepNRun};
      bp_sync    <= {bp_sync[0], i_swEnableBreakpoint};
      warm       <= {warm[0], 1'b1};
    end
  end
  for (genvar k = 0; k < NUM_BP; k++) begin : g_bp
    assign bp_match[k] = i_bpValid[k] & bp_sync[1] &
                         (i_bpAddresses[k*ADDR_WIDTH +: ADDR_WIDTH] == i_pc);
  end
  assign done    = o_cpuEnable & i_instrDone;
  assign checked = done & (state == RUN || state == STEP_INS);
  assign hit     = checked & |bp_match;
  assign leave   = state == HALT && next != HALT;
  // next-state: run beats step, breakpoints and step-mode halts only land on instruction boundaries
  always_comb begin
    next = state;
    case (state)
      HALT:     if (warm[1]) next = !step_sync[1] ? RUN :
                                    step_req ? (instr_sync[1] ? STEP_INS : STEP_CYC) : HALT;
      STEP_CYC: next = HALT;
      STEP_INS: next = done ? HALT : STEP_INS;
      RUN:      next = (hit | (done & step_sync[1])) ? HALT : RUN;
      default:  next = HALT;
    endcase
  end
  // state, registered enable/halt decode, sticky hit flags and counters
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state        <= HALT;
      o_cpuEnable  <= 1'b0;
      o_halted     <= 1'b1;
      o_bpHit      <= '0;
      o_cycleCount <= '0;
      o_instrCount <= '0;
    end else begin
      state        <= next;
      o_cpuEnable  <= next != HALT;
      o_halted     <= next == HALT;
      o_bpHit      <= leave ? '0 : o_bpHit | (checked ? bp_match : '0);
      o_cycleCount <= o_cycleCount + CNT_WIDTH'(o_cpuEnable);
      o_instrCount <= o_instrCount + CNT_WIDTH'(done);
    end
  end
endmodule
